full_adder_1: RTL and testbench
===============================

Name: full_adder_1

Overview:
- Single-bit full adder (default) with a registered result, used as the basic carry cell of the processor's ALU adder chain.
- Adds operands a, b and carry-in cin. Produces sum and carry-out cout, captured on the rising clock edge.
- The WIDTH parameter lets the same block be built as a ripple-carry chain of 1-bit cells.

Parameters:
- WIDTH, 1, operand width in bits; the sum is computed as a ripple chain of WIDTH 1-bit full-adder cells.
- REGISTERED, 1, 1 = sum/cout registered (1-cycle latency); 0 = purely combinational outputs, with clk/reset unused.

Ports:
- clk  input  1  system clock, rising-edge active.
- reset  input  1  synchronous, active-high reset.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in into bit 0.
- sum  output  WIDTH  sum bits.
- cout  output  1  carry-out of the MSB cell.

Behaviour:
- One clock, clk. Reset is synchronous and active-high.
- Cell equations per bit i:
  - s[i] = a[i] XOR b[i] XOR c[i]
  - c[i+1] = (a[i] AND b[i]) OR (c[i] AND (a[i] XOR b[i]))
  - c[0] = cin; cout = c[WIDTH].
- Arithmetic: {cout, sum} = a + b + cin, unsigned, modulo 2^(WIDTH+1). There is no overflow flag; cout is the only carry indication.
- REGISTERED=1:
  - At each rising clk edge with reset=0, sum and cout load the combinational result of the current a, b, cin.
  - Latency is exactly 1 cycle: inputs applied before edge N appear on the outputs after edge N.
  - Inputs are sampled every cycle. There is no handshake or enable, and the block is never stalled.
  - Reset: when reset=1 at a rising edge, sum=0 and cout=0, regardless of inputs.
  - Reset has priority over the data load.
  - Reset asserted mid-stream discards the in-flight result. The first valid result appears one edge after reset deasserts.
  - Before the first clock edge following power-up, outputs are undefined. Benches must apply reset or wait one edge.
- REGISTERED=0: outputs follow inputs combinationally with no latency, and reset has no effect.
- Wrap-around: all-ones operands with cin=1 give sum = all-ones and cout=1. For WIDTH=1 this is 1+1+1 -> sum=1, cout=1.
- Inputs must be stable in the setup/hold window around the clk edge. Changes between edges have no effect on the registered outputs.
- X/Z on inputs is not filtered. Behaviour is only defined for 0/1 inputs.

Test Plan:
- WIDTH=1, REGISTERED=1, all-zero case: reset for 1 cycle, then a=0, b=0, cin=0, wait ≥1 edge -> sum=0, cout=0.
- Single operand set: a=0, b=1, cin=0 -> sum=1, cout=0, one edge later. Also check the mirror case a=1, b=0, cin=0 gives the same result.
- Carry generate without carry-in: a=1, b=1, cin=0 -> sum=0, cout=1. Also check that a=0, b=0, cin=1 gives sum=1, cout=0.
- All inputs high: a=1, b=1, cin=1 -> sum=1, cout=1.
- Exhaustive and latency check: sweep all 8 input combinations, one per cycle. Each response must match the truth table exactly one edge after its inputs were applied, never on the same edge.
- Reset behaviour: drive a=1, b=1, cin=1 and assert reset for one edge -> sum=0, cout=0 on that edge. Deassert reset -> sum=1, cout=1 after the next edge.

Source files
------------

// File: rtl/full_adder_1.sv
// Ripple-carry adder built from 1-bit full-adder cells.
// The result is either registered with one cycle of latency or combinational.
module full_adder_1 #(
  parameter int unsigned WIDTH      = 1,
  parameter bit          REGISTERED = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] sum_d;
  logic             cout_d;

  assign carry[0] = cin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    logic prop;
    assign prop       = a[i] ^ b[i];
    assign sum_d[i]   = prop ^ carry[i];
    assign carry[i+1] = (a[i] & b[i]) | (carry[i] & prop);
  end

  assign cout_d = carry[WIDTH];

  if (REGISTERED) begin : g_reg
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;

    // Reset takes priority over the data load and discards any in-flight result.
    always_ff @(posedge clk) begin
      if (reset) begin
        sum_q  <= '0;
        cout_q <= 1'b0;
      end else begin
        sum_q  <= sum_d;
        cout_q <= cout_d;
      end
    end

    assign sum  = sum_q;
    assign cout = cout_q;
  end else begin : g_comb
    logic unused_clk_reset;
    assign unused_clk_reset = ^{clk, reset};

    assign sum  = sum_d;
    assign cout = cout_d;
  end

endmodule

// File: tb/tb_full_adder_1.sv
// Directed bench for full_adder_1 with WIDTH=1, REGISTERED=1.
// Checks reset, the full truth table and the one-edge output latency.
module tb_full_adder_1;

  logic clk;
  logic reset;
  logic a;
  logic b;
  logic cin;
  logic sum;
  logic cout;

  int tests_run;
  int tests_failed;

  full_adder_1 #(
    .WIDTH      (1),
    .REGISTERED (1'b1)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .sum   (sum),
    .cout  (cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs are driven 1 time unit after a rising edge; outputs are sampled likewise.
  task automatic drive(input logic va, input logic vb, input logic vc);
    a   = va;
    b   = vb;
    cin = vc;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    drive(1'b1, 1'b1, 1'b1);
    @(posedge clk);
    #1;
    tests_run++;
    if (sum !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_sum: got %b expected 0", sum);
    end
    tests_run++;
    if (cout !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_cout: got %b expected 0", cout);
    end
    reset = 1'b0;
  endtask

  task automatic test_zero;
    drive(1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    tests_run++;
    if ({cout, sum} !== 2'b00) begin
      tests_failed++;
      $display("FAIL zero: got cout,sum=%b expected 00", {cout, sum});
    end
  endtask

  task automatic test_single_operand;
    drive(1'b0, 1'b1, 1'b0);
    @(posedge clk);
    #1;
    tests_run++;
    if ({cout, sum} !== 2'b01) begin
      tests_failed++;
      $display("FAIL single_b: got cout,sum=%b expected 01", {cout, sum});
    end
    drive(1'b1, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    tests_run++;
    if ({cout, sum} !== 2'b01) begin
      tests_failed++;
      $display("FAIL single_a: got cout,sum=%b expected 01", {cout, sum});
    end
  endtask

  task automatic test_carry;
    drive(1'b1, 1'b1, 1'b0);
    @(posedge clk);
    #1;
    tests_run++;
    if ({cout, sum} !== 2'b10) begin
      tests_failed++;
      $display("FAIL carry_gen: got cout,sum=%b expected 10", {cout, sum});
    end
    drive(1'b0, 1'b0, 1'b1);
    @(posedge clk);
    #1;
    tests_run++;
    if ({cout, sum} !== 2'b01) begin
      tests_failed++;
      $display("FAIL cin_only: got cout,sum=%b expected 01", {cout, sum});
    end
  endtask

  task automatic test_all_ones;
    drive(1'b1, 1'b1, 1'b1);
    @(posedge clk);
    #1;
    tests_run++;
    if ({cout, sum} !== 2'b11) begin
      tests_failed++;
      $display("FAIL all_ones: got cout,sum=%b expected 11", {cout, sum});
    end
  endtask

  // Truth table indexed by {a, b, cin}.
  task automatic test_latency_sweep;
    logic [7:0] exp_sum;
    logic [7:0] exp_cout;
    logic [2:0] v;
    exp_sum  = 8'b1001_0110;
    exp_cout = 8'b1110_1000;
    for (int i = 0; i < 8; i++) begin
      v = 3'(i);
      drive(v[2], v[1], v[0]);
      #1;
      if (i > 0) begin
        tests_run++;
        if ({cout, sum} !== {exp_cout[i-1], exp_sum[i-1]}) begin
          tests_failed++;
          $display("FAIL sweep_hold_%0d: got cout,sum=%b expected %b before edge", i,
                   {cout, sum}, {exp_cout[i-1], exp_sum[i-1]});
        end
      end
      @(posedge clk);
      #1;
      tests_run++;
      if ({cout, sum} !== {exp_cout[i], exp_sum[i]}) begin
        tests_failed++;
        $display("FAIL sweep_%0d: got cout,sum=%b expected %b", i, {cout, sum},
                 {exp_cout[i], exp_sum[i]});
      end
    end
  endtask

  task automatic test_reset_midstream;
    drive(1'b1, 1'b1, 1'b1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    tests_run++;
    if ({cout, sum} !== 2'b00) begin
      tests_failed++;
      $display("FAIL mid_reset: got cout,sum=%b expected 00", {cout, sum});
    end
    reset = 1'b0;
    @(posedge clk);
    #1;
    tests_run++;
    if ({cout, sum} !== 2'b11) begin
      tests_failed++;
      $display("FAIL after_reset: got cout,sum=%b expected 11", {cout, sum});
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    reset        = 1'b1;
    drive(1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    test_reset();
    test_zero();
    test_single_operand();
    test_carry();
    test_all_ones();
    test_latency_sweep();
    test_reset_midstream();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
